dmem_responder: RTL and testbench

Data-memory responder that sits on the far side of the core's data port (`o_memaddr`/`o_read_en`/`o_write_en`/`o_write_data` → `i_read_data`) and closes the loop via the core's `i_exstall`. It owns a word-addressed RAM and adds a fixed number of wait states per access. While an access is pending it holds the core with a stall, then returns registered read data or commits the write.

---
 rtl/dmem_pkg.sv | 12 +
 rtl/dmem_array.sv | 31 +++
 rtl/dmem_responder.sv | 134 +++++++++++++
 tb/tb_dmem_responder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and limits for the data-memory responder.
package dmem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int unsigned CNT_W    = 4;
    localparam int unsigned WAIT_MAX = 15;

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM: synchronous write, registered read with a capture enable.
module dmem_array #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    // Contents are deliberately not reset; only the read register is.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder: stalls the core for WAIT cycles per access.
// Optional DMEM_BOUND_CHECK_EN flags and suppresses out-of-range accesses.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned WAIT   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_read_en,
    input  logic        i_write_en,
    input  logic [31:0] i_memaddr,
    input  logic [31:0] i_write_data,
    output logic [31:0] o_read_data,
    output logic        o_exstall,
    output logic        o_fault
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              req;
    logic              stall;
    logic              last_stall;
    logic              done;
    logic              cap_rd;
    logic              commit_wr;
    logic              oob;
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       ram_q;

    assign req      = i_read_en | i_write_en;
    assign word_idx = i_memaddr[ADDR_W+1:2];

`ifdef DMEM_BOUND_CHECK_EN
    logic unused_addr;
    assign unused_addr = ^i_memaddr[1:0];
    assign oob         = |i_memaddr[31:ADDR_W+2];
`else
    logic unused_addr;
    assign unused_addr = ^{i_memaddr[1:0], i_memaddr[31:ADDR_W+2]};
    assign oob         = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        stall      = 1'b0;
        last_stall = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    stall      = 1'b1;
                    cnt_nxt    = CNT_LOAD;
                    state_nxt  = BUSY;
                    last_stall = (CNT_LOAD == '0);
                end
            end
            BUSY: begin
                if (!req) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt != '0) begin
                    stall      = 1'b1;
                    cnt_nxt    = cnt - 1'b1;
                    last_stall = (cnt == CNT_W'(1));
                end else begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Read data is captured on the edge that enters the completion cycle,
    // so it is already valid while the stall is low.
    assign cap_rd    = last_stall & i_read_en & ~i_write_en;
    assign commit_wr = done & i_write_en & ~oob;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign o_exstall = stall & ~rst;

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (commit_wr),
        .re    (cap_rd),
        .addr  (word_idx),
        .wdata (i_write_data),
        .rdata (ram_q)
    );

`ifdef DMEM_BOUND_CHECK_EN
    logic rd_zero;
    logic fault;

    // An out-of-range read masks the RAM register to zero until the next read lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_zero <= 1'b0;
            fault   <= 1'b0;
        end else begin
            if (cap_rd) begin
                rd_zero <= oob;
            end
            if (done && oob) begin
                fault <= 1'b1;
            end
        end
    end

    assign o_read_data = rd_zero ? '0 : ram_q;
    assign o_fault     = fault;
`else
    assign o_read_data = ram_q;
    assign o_fault     = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (ADDR_W=12, WAIT=2).
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic        i_read_en;
    logic        i_write_en;
    logic [31:0] i_memaddr;
    logic [31:0] i_write_data;
    logic [31:0] o_read_data;
    logic        o_exstall;
    logic        o_fault;

    int unsigned n_cmp;
    int unsigned n_bad;
    int unsigned cyc;

    dmem_responder #(
        .ADDR_W (12),
        .WAIT   (2)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .i_read_en    (i_read_en),
        .i_write_en   (i_write_en),
        .i_memaddr    (i_memaddr),
        .i_write_data (i_write_data),
        .o_read_data  (o_read_data),
        .o_exstall    (o_exstall),
        .o_fault      (o_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Starts at posedge+1; returns after the edge that closes the completion cycle.
    task automatic access(input logic wr, input logic rd, input logic [31:0] addr,
                          input logic [31:0] data, output int stalls, output logic [31:0] rdata);
        i_write_en   = wr;
        i_read_en    = rd;
        i_memaddr    = addr;
        i_write_data = data;
        stalls       = 0;
        #1;
        while (o_exstall && stalls < 20) begin
            stalls++;
            @(posedge clk); #1;
        end
        rdata = o_read_data;
        @(posedge clk); #1;
    endtask

    task automatic idle_cycle();
        i_write_en = 1'b0;
        i_read_en  = 1'b0;
        @(posedge clk); #1;
    endtask

    int          st;
    logic [31:0] rd;
    int unsigned c0;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst          = 1'b1;
        i_read_en    = 1'b1;
        i_write_en   = 1'b0;
        i_memaddr    = 32'h10;
        i_write_data = '0;
        #2;
        check("rst_stall_forced", {31'd0, o_exstall}, 32'd0);
        check("rst_rdata", o_read_data, 32'd0);
        check("rst_fault", {31'd0, o_fault}, 32'd0);
        @(posedge clk); #1;
        i_read_en = 1'b0;
        rst       = 1'b0;
        @(posedge clk); #1;

        // Write then read back
        access(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, st, rd);
        check("wr10_stalls", 32'(st), 32'd2);
        check("wr10_rdata_untouched", rd, 32'd0);
        access(1'b0, 1'b1, 32'h10, 32'h0, st, rd);
        check("rd10_stalls", 32'(st), 32'd2);
        check("rd10_data", rd, 32'hDEADBEEF);
        idle_cycle();
        idle_cycle();
        check("rd10_held", o_read_data, 32'hDEADBEEF);

        // Back-to-back write then read, no idle gap
        c0 = cyc;
        access(1'b1, 1'b0, 32'h20, 32'h11111111, st, rd);
        check("b2b_wr_stalls", 32'(st), 32'd2);
        access(1'b0, 1'b1, 32'h20, 32'h0, st, rd);
        check("b2b_rd_stalls", 32'(st), 32'd2);
        check("b2b_rd_data", rd, 32'h11111111);
        check("b2b_total_cycles", cyc - c0, 32'd6);
        idle_cycle();

        // Read and write both high: write wins, read register untouched
        access(1'b1, 1'b1, 32'h24, 32'h5, st, rd);
        check("both_stalls", 32'(st), 32'd2);
        check("both_rdata_unchanged", rd, 32'h11111111);
        idle_cycle();
        check("both_rdata_after", o_read_data, 32'h11111111);
        access(1'b0, 1'b1, 32'h24, 32'h0, st, rd);
        check("both_ram9", rd, 32'h5);
        idle_cycle();

        // Byte offset bits ignored
        access(1'b0, 1'b1, 32'h13, 32'h0, st, rd);
        check("byte_off_rd", rd, 32'hDEADBEEF);
        idle_cycle();

        // Request dropped mid-access aborts the write
        access(1'b1, 1'b0, 32'h34, 32'h77, st, rd);
        idle_cycle();
        i_write_en   = 1'b1;
        i_memaddr    = 32'h34;
        i_write_data = 32'h99;
        @(posedge clk); #1;
        i_write_en = 1'b0;
        @(posedge clk); #1;
        check("abort_stall_low", {31'd0, o_exstall}, 32'd0);
        check("abort_rdata_unchanged", o_read_data, 32'hDEADBEEF);
        access(1'b0, 1'b1, 32'h34, 32'h0, st, rd);
        check("abort_stalls", 32'(st), 32'd2);
        check("abort_no_write", rd, 32'h77);
        idle_cycle();

        // Reset in second stall cycle of a write discards it
        access(1'b1, 1'b0, 32'h30, 32'hAAAA5555, st, rd);
        idle_cycle();
        i_write_en   = 1'b1;
        i_memaddr    = 32'h30;
        i_write_data = 32'h12345678;
        #1;
        check("rstmid_stall1", {31'd0, o_exstall}, 32'd1);
        @(posedge clk); #1;
        check("rstmid_stall2", {31'd0, o_exstall}, 32'd1);
        rst = 1'b1;
        #1;
        check("rstmid_stall_drop", {31'd0, o_exstall}, 32'd0);
        check("rstmid_rdata_reset", o_read_data, 32'd0);
        i_write_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        access(1'b0, 1'b1, 32'h30, 32'h0, st, rd);
        check("rstmid_idle_stalls", 32'(st), 32'd2);
        check("rstmid_ram12_kept", rd, 32'hAAAA5555);
        idle_cycle();

`ifdef DMEM_BOUND_CHECK_EN
        access(1'b1, 1'b0, 32'h0, 32'hCAFEF00D, st, rd);
        idle_cycle();
        access(1'b1, 1'b0, 32'h0001_0000, 32'h00000BAD, st, rd);
        check("oob_wr_stalls", 32'(st), 32'd2);
        check("oob_fault_set", {31'd0, o_fault}, 32'd1);
        idle_cycle();
        access(1'b0, 1'b1, 32'h0, 32'h0, st, rd);
        check("oob_no_ram_change", rd, 32'hCAFEF00D);
        access(1'b0, 1'b1, 32'h0001_0000, 32'h0, st, rd);
        check("oob_rd_stalls", 32'(st), 32'd2);
        check("oob_rd_zero", rd, 32'd0);
        idle_cycle();
        check("oob_fault_sticky", {31'd0, o_fault}, 32'd1);
        rst = 1'b1;
        #1;
        check("oob_fault_clear", {31'd0, o_fault}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
`else
        access(1'b0, 1'b1, 32'h0001_0010, 32'h0, st, rd);
        check("alias_stalls", 32'(st), 32'd2);
        check("alias_rd", rd, 32'hDEADBEEF);
        idle_cycle();
        check("fault_tied_low", {31'd0, o_fault}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
